// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU, branch and mul/div encodings for the execute stage
package ex_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BRU_BEQ  = 3'd0;
  localparam logic [2:0] BRU_BNE  = 3'd1;
  localparam logic [2:0] BRU_JAL  = 3'd2;
  localparam logic [2:0] BRU_JALR = 3'd3;
  localparam logic [2:0] BRU_BLT  = 3'd4;
  localparam logic [2:0] BRU_BGE  = 3'd5;
  localparam logic [2:0] BRU_BLTU = 3'd6;
  localparam logic [2:0] BRU_BGEU = 3'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M mul/div unit; EX_FAST_MUL_EN gives single-cycle multiply
module ex_muldiv
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d, rneg_q, rneg_d;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, step_lo, quo_s, rem_s, fin;
  logic [32:0] mul_sum, rem_shift, trial, step_hi;
  logic [63:0] prod, prod_s;
`ifdef EX_FAST_MUL_EN
  logic [63:0] fast_prod, fast_res;
`endif

  // Operands are turned into magnitudes; the sign is reapplied after the last step.
  always_comb begin
    a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = a_signed & a[31];
    b_neg    = b_signed & b[31];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
`ifdef EX_FAST_MUL_EN
    fast_prod = {32'b0, a_mag} * {32'b0, b_mag};
    fast_res  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif

    mul_sum   = lo_q[0] ? hi_q + {1'b0, b_q} : hi_q;
    rem_shift = {hi_q[31:0], lo_q[31]};
    trial     = rem_shift - {1'b0, b_q};
    if (op_q[2]) begin
      if (!trial[32]) begin
        step_hi = trial;
        step_lo = {lo_q[30:0], 1'b1};
      end else begin
        step_hi = rem_shift;
        step_lo = {lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, mul_sum[32:1]};
      step_lo = {mul_sum[0], lo_q[31:1]};
    end

    prod   = {step_hi[31:0], step_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -step_lo : step_lo;
    rem_s  = rneg_q ? -step_hi[31:0] : step_hi[31:0];
    case (op_q)
      MD_MUL:                       fin = prod_s[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin = prod_s[63:32];
      MD_DIV, MD_DIVU:              fin = quo_s;
      default:                      fin = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d    = op;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          hi_d    = '0;
          lo_d    = a_mag;
          b_d     = b_mag;
          cnt_d   = 5'd31;
          state_d = MD_BUSY;
          if (op[2] && b == '0) begin
            result_d = op[1] ? a : '1;
            state_d  = MD_DONE;
          end else if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == '1) begin
            result_d = op[1] ? '0 : 32'h8000_0000;
            state_d  = MD_DONE;
          end
`ifdef EX_FAST_MUL_EN
          else if (!op[2]) begin
            result_d = (op == MD_MUL) ? fast_res[31:0] : fast_res[63:32];
            state_d  = MD_DONE;
          end
`endif
        end
      end
      MD_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          result_d = fin;
          state_d  = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == MD_IDLE && start && !flush) || (state_q == MD_BUSY);
  assign done   = (state_q == MD_DONE);
  assign result = result_q;
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, branch unit, mul/div (EX_FAST_MUL_EN in ex_muldiv)
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  input  logic [XLEN-1:0] imm_in,
  input  logic            alu_src_in,
  input  logic [3:0]      alu_op_in,
  input  logic            branch_in,
  input  logic [2:0]      bru_op_in,
  input  logic            md_en_in,
  input  logic [2:0]      md_op_in,
  input  logic [4:0]      exmem_rd,
  input  logic [4:0]      memwb_rd,
  input  logic            exmem_regwrite,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] exmem_val,
  input  logic [XLEN-1:0] memwb_val,
  input  logic            flush_in,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic            br_taken_out,
  output logic [XLEN-1:0] br_target_out,
  output logic            stall_out,
  output logic            wb_kill_out
);
  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res, jalr_sum;
  logic            cond, is_jump, md_busy, md_done;
  logic [XLEN-1:0] md_result;

  ex_muldiv u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_en_in),
    .op     (md_op_in),
    .a      (fwd_a),
    .b      (fwd_b),
    .flush  (flush_in),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // EX/MEM is checked last so it overrides the older MEM/WB value.
  always_comb begin
    fwd_a = rs1_val;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs1_idx) fwd_a = memwb_val;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs1_idx) fwd_a = exmem_val;
    fwd_b = rs2_val;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs2_idx) fwd_b = memwb_val;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs2_idx) fwd_b = exmem_val;

    alu_b = alu_src_in ? imm_in : fwd_b;
    case (alu_op_in)
      ALU_ADD:   alu_res = fwd_a + alu_b;
      ALU_SUB:   alu_res = fwd_a - alu_b;
      ALU_SLL:   alu_res = fwd_a << alu_b[4:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
      ALU_XOR:   alu_res = fwd_a ^ alu_b;
      ALU_SRL:   alu_res = fwd_a >> alu_b[4:0];
      ALU_SRA:   alu_res = $signed(fwd_a) >>> alu_b[4:0];
      ALU_OR:    alu_res = fwd_a | alu_b;
      ALU_AND:   alu_res = fwd_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase

    case (bru_op_in)
      BRU_BEQ:  cond = (fwd_a == fwd_b);
      BRU_BNE:  cond = (fwd_a != fwd_b);
      BRU_BLT:  cond = ($signed(fwd_a) < $signed(fwd_b));
      BRU_BGE:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      BRU_BLTU: cond = (fwd_a < fwd_b);
      BRU_BGEU: cond = (fwd_a >= fwd_b);
      default:  cond = 1'b1;
    endcase
    is_jump  = (bru_op_in == BRU_JAL) || (bru_op_in == BRU_JALR);
    jalr_sum = fwd_a + imm_in;
  end

  assign stall_out      = md_busy & ~rst;
  assign wb_kill_out    = stall_out;
  assign br_taken_out   = branch_in & cond & ~stall_out & ~rst;
  assign br_target_out  = (bru_op_in == BRU_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_in + imm_in;
  assign store_data_out = fwd_b;
  assign result_out     = md_done ? md_result
                        : (branch_in && is_jump) ? pc_in + XLEN'(4) : alu_res;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk, rst;
  logic [31:0] pc_in, rs1_val, rs2_val, imm_in, exmem_val, memwb_val;
  logic [4:0]  rs1_idx, rs2_idx, exmem_rd, memwb_rd;
  logic        alu_src_in, branch_in, md_en_in, exmem_regwrite, memwb_regwrite, flush_in;
  logic [3:0]  alu_op_in;
  logic [2:0]  bru_op_in, md_op_in;
  logic [31:0] result_out, store_data_out, br_target_out;
  logic        br_taken_out, stall_out, wb_kill_out;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .imm_in(imm_in), .alu_src_in(alu_src_in),
    .alu_op_in(alu_op_in), .branch_in(branch_in), .bru_op_in(bru_op_in),
    .md_en_in(md_en_in), .md_op_in(md_op_in), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_val(exmem_val), .memwb_val(memwb_val), .flush_in(flush_in),
    .result_out(result_out), .store_data_out(store_data_out), .br_taken_out(br_taken_out),
    .br_target_out(br_target_out), .stall_out(stall_out), .wb_kill_out(wb_kill_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    pc_in = '0; rs1_val = '0; rs2_val = '0; imm_in = '0; exmem_val = '0; memwb_val = '0;
    rs1_idx = '0; rs2_idx = '0; exmem_rd = '0; memwb_rd = '0;
    alu_src_in = 0; branch_in = 0; md_en_in = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    flush_in = 0; alu_op_in = ALU_ADD; bru_op_in = BRU_BEQ; md_op_in = MD_MUL;
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] idx, input logic [31:0] rf);
    if (idx != 0 && exmem_regwrite && exmem_rd == idx) return exmem_val;
    if (idx != 0 && memwb_regwrite && memwb_rd == idx) return memwb_val;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << sh;
      ALU_SLT:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return 32'(int'(a) >>> sh);
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      default:   return b;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      BRU_BEQ:  return a == b;
      BRU_BNE:  return a != b;
      BRU_BLT:  return int'(a) < int'(b);
      BRU_BGE:  return int'(a) >= int'(b);
      BRU_BLTU: return a < b;
      BRU_BGEU: return a >= b;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000;
                   p = sa / sb; return p[31:0]; end
      MD_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      MD_REM:    begin if (b == 0) return a; if (ovf) return 32'd0;
                   p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int stall_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < MD_DIV) return MUL_STALL;
    if (b == 0) return 1;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n;
    logic [31:0] exp_r;
    int exp_n;
    exp_r = md_ref(op, a, b);
    exp_n = stall_ref(op, a, b);
    @(negedge clk);
    clear_inputs();
    rs1_idx = 5'd1; rs2_idx = 5'd2; rs1_val = a; rs2_val = b;
    md_en_in = 1; md_op_in = op;
    #2;
    n = 0;
    while (stall_out === 1'b1 && n < 100) begin
      n++;
      n_cmp++;
      if (wb_kill_out !== 1'b1) begin n_err++; $display("FAIL %s wb_kill got %b want 1", name, wb_kill_out); end
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (n != exp_n) begin n_err++; $display("FAIL %s stall_cycles got %0d want %0d", name, n, exp_n); end
    n_cmp++;
    if (result_out !== exp_r) begin n_err++; $display("FAIL %s result got %h want %h", name, result_out, exp_r); end
    md_en_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #2;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_out); end
    n_cmp++; if (br_taken_out !== 1'b0) begin n_err++; $display("FAIL reset_br got %b want 0", br_taken_out); end
    n_cmp++; if (wb_kill_out !== 1'b0) begin n_err++; $display("FAIL reset_kill got %b want 0", wb_kill_out); end
    n_cmp++; if (result_out !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result_out); end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    rs1_idx = 5; rs1_val = 32'd1; exmem_rd = 5; memwb_rd = 5; exmem_regwrite = 1; memwb_regwrite = 1;
    exmem_val = 32'd7; memwb_val = 32'd9;
    #2;
    n_cmp++; if (result_out !== 32'd7) begin n_err++; $display("FAIL fwd_exmem got %h want 7", result_out); end
    exmem_rd = 0;
    #2;
    n_cmp++; if (result_out !== 32'd9) begin n_err++; $display("FAIL fwd_memwb got %h want 9", result_out); end
    for (int i = 0; i < 30; i++) begin
      rs1_idx = 5'($urandom_range(0, 3)); rs2_idx = 5'($urandom_range(0, 3));
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
      rs1_val = $urandom; rs2_val = $urandom; exmem_val = $urandom; memwb_val = $urandom;
      #2;
      n_cmp++;
      if (result_out !== fwd_ref(rs1_idx, rs1_val) + fwd_ref(rs2_idx, rs2_val))
        begin n_err++; $display("FAIL fwd_rand result got %h want %h", result_out, fwd_ref(rs1_idx, rs1_val) + fwd_ref(rs2_idx, rs2_val)); end
      n_cmp++;
      if (store_data_out !== fwd_ref(rs2_idx, rs2_val))
        begin n_err++; $display("FAIL fwd_rand store got %h want %h", store_data_out, fwd_ref(rs2_idx, rs2_val)); end
    end
  endtask

  task automatic test_alu();
    logic [31:0] b, exp_r;
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 40; i++) begin
      alu_op_in = 4'($urandom_range(0, 10)); alu_src_in = 1'($urandom);
      rs1_val = $urandom; rs2_val = $urandom; imm_in = $urandom;
      if (i % 4 == 0) rs2_val = rs1_val;
      #2;
      b = alu_src_in ? imm_in : rs2_val;
      exp_r = alu_ref(alu_op_in, rs1_val, b);
      n_cmp++;
      if (result_out !== exp_r) begin n_err++; $display("FAIL alu op=%0d got %h want %h", alu_op_in, result_out, exp_r); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] v[4];
    logic exp_t;
    logic [31:0] exp_tgt;
    v[0] = 32'd0; v[1] = 32'd1; v[2] = 32'hFFFF_FFFF; v[3] = 32'h8000_0000;
    @(negedge clk);
    clear_inputs();
    branch_in = 1; bru_op_in = BRU_BLT; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'd1;
    pc_in = 32'h100; imm_in = 32'h20;
    #2;
    n_cmp++; if (br_taken_out !== 1'b1) begin n_err++; $display("FAIL blt_taken got %b want 1", br_taken_out); end
    n_cmp++; if (br_target_out !== 32'h120) begin n_err++; $display("FAIL blt_target got %h want 120", br_target_out); end
    bru_op_in = BRU_BLTU;
    #2;
    n_cmp++; if (br_taken_out !== 1'b0) begin n_err++; $display("FAIL bltu_taken got %b want 0", br_taken_out); end
    for (int i = 0; i < 40; i++) begin
      bru_op_in = 3'($urandom_range(0, 7)); branch_in = 1'($urandom_range(0, 3) != 0);
      rs1_val = v[$urandom_range(0, 3)]; rs2_val = v[$urandom_range(0, 3)];
      pc_in = $urandom & 32'hFFFF_FFFC; imm_in = $urandom;
      #2;
      exp_t = branch_in && br_ref(bru_op_in, rs1_val, rs2_val);
      exp_tgt = (bru_op_in == BRU_JALR) ? ((rs1_val + imm_in) & 32'hFFFF_FFFE) : pc_in + imm_in;
      n_cmp++;
      if (br_taken_out !== exp_t) begin n_err++; $display("FAIL br_rand op=%0d taken got %b want %b", bru_op_in, br_taken_out, exp_t); end
      n_cmp++;
      if (br_target_out !== exp_tgt) begin n_err++; $display("FAIL br_rand target got %h want %h", br_target_out, exp_tgt); end
      if (branch_in && (bru_op_in == BRU_JAL || bru_op_in == BRU_JALR)) begin
        n_cmp++;
        if (result_out !== pc_in + 32'd4) begin n_err++; $display("FAIL link got %h want %h", result_out, pc_in + 32'd4); end
      end
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] a, b;
    logic [2:0] op;
    run_md(MD_DIV, 32'd100, 32'd7, "div_100_7");
    run_md(MD_REM, 32'd100, 32'd7, "rem_100_7");
    run_md(MD_DIV, 32'd1234, 32'd0, "div_by_0");
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      if (i % 5 == 1) b = 32'd0;
      if (i % 5 == 2) b = 32'hFFFF_FFFF;
      if (i % 5 == 3) b = b >> 20;
      run_md(op, a, b, "md_rand");
    end
  endtask

  task automatic test_back_to_back();
    run_md(MD_MUL, 32'hFFFF_FFF9, 32'd6, "b2b_mul");
    run_md(MD_DIVU, 32'hFFFF_FFFF, 32'd3, "b2b_divu");
    run_md(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, "b2b_mulhsu");
  endtask

  task automatic test_flush();
    @(negedge clk);
    clear_inputs();
    rs1_val = 32'd100; rs2_val = 32'd7; md_en_in = 1; md_op_in = MD_DIV;
    repeat (10) @(negedge clk);
    #2;
    md_en_in = 0; branch_in = 1; bru_op_in = BRU_BEQ; rs1_val = 32'd5; rs2_val = 32'd5; flush_in = 1;
    #1;
    n_cmp++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL flush_busy_stall got %b want 1", stall_out); end
    n_cmp++; if (br_taken_out !== 1'b0) begin n_err++; $display("FAIL br_during_stall got %b want 0", br_taken_out); end
    @(negedge clk);
    flush_in = 0; branch_in = 0;
    #2;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b want 0", stall_out); end
    n_cmp++; if (result_out !== 32'd10) begin n_err++; $display("FAIL flush_result got %h want a", result_out); end
    repeat (3) @(negedge clk);
    #2;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall got %b want 0", stall_out); end
    run_md(MD_REMU, 32'd50, 32'd8, "after_flush");
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    clear_inputs();
    rs1_val = 32'd100; rs2_val = 32'd7; md_en_in = 1; md_op_in = MD_DIV;
    repeat (5) @(negedge clk);
    #2;
    rst = 1;
    clear_inputs();
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rstbusy_stall got %b want 0", stall_out); end
    n_cmp++; if (wb_kill_out !== 1'b0) begin n_err++; $display("FAIL rstbusy_kill got %b want 0", wb_kill_out); end
    n_cmp++; if (br_taken_out !== 1'b0) begin n_err++; $display("FAIL rstbusy_br got %b want 0", br_taken_out); end
    n_cmp++; if (result_out !== 32'd0) begin n_err++; $display("FAIL rstbusy_result got %h want 0", result_out); end
    @(negedge clk);
    rst = 0;
    #2;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rstbusy_idle got %b want 0", stall_out); end
    run_md(MD_DIV, 32'd100, 32'd7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
